// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after MAX_D_STREAK data wins.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_stall,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_stall,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

    owner_t     r_owner;
    logic [3:0] r_streak;
    logic       r_d_zero;

    logic w_fetch_turn;
    logic w_fetch_grant;
    logic w_data_grant;
    logic w_misalign;

    // Grants are gated by rst so nothing reaches memory while reset is held.
    assign w_fetch_turn  = (r_streak == 4'(MAX_D_STREAK));
    assign w_data_grant  = rst & d_req & ~(if_req & w_fetch_turn);
    assign w_fetch_grant = rst & if_req & ~w_data_grant;
    assign w_misalign    = (d_be == 4'hF) && (d_addr[1:0] != 2'b00);

    assign if_stall = rst & if_req & ~w_fetch_grant;
    assign d_stall  = rst & d_req & ~w_data_grant;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_fetch_grant) begin
            mem_en   = 1'b1;
            mem_addr = if_addr >> 2;
        end else if (w_data_grant && !w_misalign) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_be : 4'h0;
            mem_addr  = d_addr >> 2;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= IDLE;
            r_streak <= 4'd0;
            r_d_zero <= 1'b0;
        end else begin
            if (w_fetch_grant) begin
                r_owner <= FETCH;
            end else if (w_data_grant) begin
                r_owner <= DATA;
            end else begin
                r_owner <= IDLE;
            end
            // Stores and misaligned accesses complete with zero read data.
            r_d_zero <= w_data_grant & (d_we | w_misalign);
            if (w_data_grant && if_req) begin
                r_streak <= r_streak + 4'd1;
            end else begin
                r_streak <= 4'd0;
            end
        end
    end

    assign if_valid = (r_owner == FETCH) & ~if_flush;
    assign if_rdata = if_valid ? mem_rdata : 32'h0;
    assign d_valid  = (r_owner == DATA);
    assign d_rdata  = (d_valid && !r_d_zero) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_mem_arbiter;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_stall;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_stall;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(MAXD)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_stall(if_stall), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural model: who answers this cycle, and how long fetch has been starved.
    int          m_waits;
    int          m_owner;      // 0 none, 1 fetch, 2 data
    bit          m_zero;
    bit          e_fg, e_dg, e_mis;
    logic [3:0]  e_ctrl_we;
    logic        e_en;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
    logic        e_if_valid, e_d_valid;

    function automatic void model_eval();
        int own;
        e_fg  = 1'b0;
        e_dg  = 1'b0;
        e_mis = (d_be == 4'hF) && ((d_addr % 4) != 0);
        if (rst === 1'b1) begin
            if (if_req && d_req) begin
                if (m_waits == MAXD) e_fg = 1'b1;
                else e_dg = 1'b1;
            end else begin
                e_fg = if_req;
                e_dg = d_req;
            end
        end
        e_en      = e_fg || (e_dg && !e_mis);
        e_ctrl_we = (e_dg && !e_mis && d_we) ? d_be : 4'h0;
        e_addr    = e_fg ? (if_addr / 4) : ((e_dg && !e_mis) ? (d_addr / 4) : 32'h0);
        e_wdata   = (e_dg && !e_mis && !e_fg) ? d_wdata : 32'h0;
        own        = (rst === 1'b1) ? m_owner : 0;
        e_if_valid = (own == 1) && !if_flush;
        e_if_rdata = e_if_valid ? mem_rdata : 32'h0;
        e_d_valid  = (own == 2);
        e_d_rdata  = (e_d_valid && !m_zero) ? mem_rdata : 32'h0;
    endfunction

    function automatic void model_commit();
        if (rst !== 1'b1) begin
            m_owner = 0;
            m_waits = 0;
            m_zero  = 1'b0;
        end else begin
            m_owner = e_fg ? 1 : (e_dg ? 2 : 0);
            m_zero  = e_dg && (d_we || e_mis);
            m_waits = (e_dg && if_req) ? m_waits + 1 : 0;
        end
    endfunction

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h20; if_flush = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'h55;
        mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_vec++;
            if ({if_stall, d_stall, mem_en, mem_we, if_valid, d_valid} !== 9'h0) begin
                n_err++;
                $display("FAIL reset_ctrl: got %b expected 0", {if_stall, d_stall, mem_en, mem_we, if_valid, d_valid});
            end
            n_vec++;
            if ({if_rdata, d_rdata, mem_addr} !== 96'h0) begin
                n_err++;
                $display("FAIL reset_data: if_rdata %h d_rdata %h mem_addr %h expected 0", if_rdata, d_rdata, mem_addr);
            end
            next_cycle();
        end
        idle_inputs();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        logic [31:0] rd;
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h8;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) if_req = 1'b0;
            rd = $urandom(); mem_rdata = rd;
            #3;
            n_vec++;
            if (c < 3 && (mem_addr !== 32'd2 || if_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 4'h0)) begin
                n_err++;
                $display("FAIL fetch_grant c%0d: mem_addr %h stall %b en %b we %h expected 2/0/1/0", c, mem_addr, if_stall, mem_en, mem_we);
            end else if (c == 3 && mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_idle: mem_en %b expected 0", mem_en);
            end
            n_vec++;
            if (if_valid !== (c > 0) || if_rdata !== ((c > 0) ? rd : 32'h0)) begin
                n_err++;
                $display("FAIL fetch_resp c%0d: valid %b rdata %h expected %b %h", c, if_valid, if_rdata, c > 0, (c > 0) ? rd : 32'h0);
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        logic [31:0] rd;
        idle_inputs();
        next_cycle();
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'hC;
        for (int c = 0; c < 7; c++) begin
            bit exp_f;
            exp_f = (c == 4);
            rd = $urandom(); mem_rdata = rd;
            #3;
            n_vec++;
            if (if_stall !== !exp_f || d_stall !== exp_f || mem_addr !== (exp_f ? 32'h10 : 32'h3)) begin
                n_err++;
                $display("FAIL contention c%0d: if_stall %b d_stall %b mem_addr %h expected %b %b %h",
                         c, if_stall, d_stall, mem_addr, !exp_f, exp_f, exp_f ? 32'h10 : 32'h3);
            end
            n_vec++;
            if (c > 0 && (d_valid !== (c != 5) || if_valid !== (c == 5) || d_rdata !== ((c != 5) ? rd : 32'h0))) begin
                n_err++;
                $display("FAIL contention_resp c%0d: d_valid %b if_valid %b d_rdata %h expected %b %b", c, d_valid, if_valid, d_rdata, c != 5, c == 5);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_store();
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'hA5A5_A5A5;
        #3;
        n_vec++;
        if (mem_we !== 4'b0011 || mem_addr !== 32'd4 || mem_wdata !== 32'hDEAD_BEEF || mem_en !== 1'b1 || d_stall !== 1'b0) begin
            n_err++;
            $display("FAIL store_req: we %b addr %h wdata %h en %b stall %b expected 0011 4 deadbeef 1 0", mem_we, mem_addr, mem_wdata, mem_en, d_stall);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hFFFF_0001;
        #3;
        n_vec++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL store_resp: d_valid %b d_rdata %h mem_en %b expected 1 0 0", d_valid, d_rdata, mem_en);
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        idle_inputs();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h6;
        #3;
        n_vec++;
        if (mem_en !== 1'b0 || mem_we !== 4'h0 || d_stall !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_req: mem_en %b mem_we %h d_stall %b expected 0 0 0", mem_en, mem_we, d_stall);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hFFFF_FFFF;
        #3;
        n_vec++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL misalign_resp: d_valid %b d_rdata %h expected 1 0", d_valid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h100;
        #3;
        n_vec++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL flush_n: mem_en %b mem_addr %h expected 1 40", mem_en, mem_addr);
        end
        next_cycle();
        if_addr = 32'h200; if_flush = 1'b1;
        rd = $urandom(); mem_rdata = rd;
        #3;
        n_vec++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h0 || if_stall !== 1'b0 || mem_addr !== 32'h80) begin
            n_err++;
            $display("FAIL flush_n1: if_valid %b if_rdata %h if_stall %b mem_addr %h expected 0 0 0 80", if_valid, if_rdata, if_stall, mem_addr);
        end
        next_cycle();
        idle_inputs();
        rd = $urandom(); mem_rdata = rd;
        #3;
        n_vec++;
        if (if_valid !== 1'b1 || if_rdata !== rd) begin
            n_err++;
            $display("FAIL flush_n2: if_valid %b if_rdata %h expected 1 %h", if_valid, if_rdata, rd);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        idle_inputs();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h20;
        #3;
        n_vec++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h8) begin
            n_err++;
            $display("FAIL rstmid_grant: mem_en %b mem_addr %h expected 1 8", mem_en, mem_addr);
        end
        next_cycle();
        d_req = 1'b1; if_req = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({d_valid, if_valid, d_stall, if_stall, mem_en, mem_we} !== 9'h0 || d_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_now: ctrl %b d_rdata %h expected 0 0", {d_valid, if_valid, d_stall, if_stall, mem_en, mem_we}, d_rdata);
        end
        next_cycle();
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h4;
        rst = 1'b1;
        #3;
        n_vec++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h1 || d_valid !== 1'b0 || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_release: mem_en %b mem_addr %h d_valid %b if_valid %b expected 1 1 0 0", mem_en, mem_addr, d_valid, if_valid);
        end
        next_cycle();
        idle_inputs();
        rd = $urandom(); mem_rdata = rd;
        #3;
        n_vec++;
        if (if_valid !== 1'b1 || if_rdata !== rd || d_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_after: if_valid %b if_rdata %h d_valid %b expected 1 %h 0", if_valid, if_rdata, d_valid, rd);
        end
        next_cycle();
    endtask

    task automatic test_random();
        rst = 1'b0;
        idle_inputs();
        m_owner = 0; m_waits = 0; m_zero = 1'b0;
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] r;
            rst      = (($urandom() % 60) != 0);
            if_req   = (($urandom() % 4) != 0);
            if_addr  = $urandom() & 32'hFFFF_FFFC;
            if_flush = (($urandom() % 6) == 0);
            d_req    = (($urandom() % 4) != 0);
            d_we     = $urandom() % 2;
            r        = $urandom();
            d_be     = (r % 3 == 0) ? 4'hF : 4'(r >> 4);
            d_addr   = $urandom();
            if ($urandom() % 2) d_addr = d_addr & 32'hFFFF_FFFC;
            d_wdata  = $urandom();
            mem_rdata = $urandom();
            model_eval();
            #3;
            n_vec++;
            if ({if_stall, d_stall, mem_en, mem_we} !== {if_req & rst & !e_fg, d_req & rst & !e_dg, e_en, e_ctrl_we}) begin
                n_err++;
                $display("FAIL rand_ctrl c%0d: got %b expected %b", c, {if_stall, d_stall, mem_en, mem_we},
                         {if_req & rst & !e_fg, d_req & rst & !e_dg, e_en, e_ctrl_we});
            end
            if (!(e_dg && e_mis)) begin
                n_vec++;
                if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                    n_err++;
                    $display("FAIL rand_mem c%0d: addr %h wdata %h expected %h %h", c, mem_addr, mem_wdata, e_addr, e_wdata);
                end
            end
            n_vec++;
            if (if_valid !== e_if_valid || if_rdata !== e_if_rdata) begin
                n_err++;
                $display("FAIL rand_if c%0d: valid %b rdata %h expected %b %h", c, if_valid, if_rdata, e_if_valid, e_if_rdata);
            end
            n_vec++;
            if (d_valid !== e_d_valid || d_rdata !== e_d_rdata) begin
                n_err++;
                $display("FAIL rand_d c%0d: valid %b rdata %h expected %b %h", c, d_valid, d_rdata, e_d_valid, e_d_rdata);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        mem_rdata = 32'h0;
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_contention();
        test_store();
        test_misaligned();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
